lsu_mem_access: RTL and testbench



---
 rtl/lsu_mem_access.sv | 198 +++++++++++++++++++
 tb/tb_lsu_mem_access.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: load/store access unit.
// Accepts one load/store request at a time. Each legal request becomes a single
// word-aligned valid/ready transaction on the data-memory port. The unit then
// returns extended load data, or a store acknowledge, to writeback.
//
// State table
//   state  | meaning
//   IDLE   | reqReady high, waiting for a request
//   REQ    | memReqValid high, request fields held until memReqReady
//   WAIT   | request accepted by memory, waiting for memRespValid
//   DONE   | respValid high, result held until respReady
//
// Ports
//   clk, rst_n                   core clock, async active-low reset
//   reqValid/reqReady            request handshake from execute
//   readMemEnable/writeMemEnable load / store select from the decoder
//   memOP                        funct3 size/sign code
//   addr, storeData              effective address, rs2 value
//   respValid/respReady          result handshake to writeback
//   loadData, accessErr          extended load result, error flag
//   memReqValid/memReqReady      memory request handshake
//   memWen, memAddr, memWdata, memWmask   memory request fields
//   memRespValid, memRdata       memory read data / write ack
module lsu_mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic                readMemEnable,
    input  logic                writeMemEnable,
    input  logic [2:0]          memOP,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   storeData,
    output logic                respValid,
    input  logic                respReady,
    output logic [DATA_W-1:0]   loadData,
    output logic                accessErr,
    output logic                memReqValid,
    input  logic                memReqReady,
    output logic                memWen,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memWdata,
    output logic [DATA_W/8-1:0] memWmask,
    input  logic                memRespValid,
    input  logic [DATA_W-1:0]   memRdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic                wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   load_q;
    logic                err_q;

    logic                is_mem;
    logic                illegal;
    logic                accept;
    logic [DATA_W/8-1:0] st_mask;
    logic [DATA_W-1:0]   st_wdata;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   ld_ext;

    assign accept = (state_q == S_IDLE) && reqValid;

    // Request legality. The opcode and alignment checks only apply when the
    // request actually touches memory.
    always_comb begin
        is_mem  = readMemEnable | writeMemEnable;
        illegal = 1'b0;
        if (readMemEnable && writeMemEnable) begin
            illegal = 1'b1;
        end else if (is_mem) begin
            if (memOP inside {3'b011, 3'b110, 3'b111}) begin
                illegal = 1'b1;
            end else if (writeMemEnable && memOP[2]) begin
                illegal = 1'b1;
            end else if ((memOP[1:0] == 2'b01) && addr[0]) begin
                illegal = 1'b1;
            end else if ((memOP[1:0] == 2'b10) && (addr[1:0] != 2'b00)) begin
                illegal = 1'b1;
            end
        end
    end

    // Store byte lanes: the data is replicated across the word so the strobe
    // alone selects the written bytes.
    always_comb begin
        st_mask  = '0;
        st_wdata = '0;
        if (writeMemEnable) begin
            case (memOP[1:0])
                2'b00: begin
                    st_mask  = 4'b0001 << addr[1:0];
                    st_wdata = {4{storeData[7:0]}};
                end
                2'b01: begin
                    st_mask  = 4'b0011 << {addr[1], 1'b0};
                    st_wdata = {2{storeData[15:0]}};
                end
                default: begin
                    st_mask  = 4'b1111;
                    st_wdata = storeData;
                end
            endcase
        end
    end

    // Load extraction from the returned word. Word loads are always aligned,
    // so the shifted word equals the raw word for them.
    always_comb begin
        shifted = memRdata >> {addr_q[1:0], 3'b000};
        case (op_q)
            3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_ext = {24'd0, shifted[7:0]};
            3'b101:  ld_ext = {16'd0, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (reqValid) begin
                    state_d = (illegal || !is_mem) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (memReqReady) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (memRespValid) state_d = S_DONE;
            end
            S_DONE: begin
                if (respReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= memOP;
                wen_q   <= writeMemEnable;
                addr_q  <= addr;
                wdata_q <= st_wdata;
                wmask_q <= st_mask;
                err_q   <= illegal;
                load_q  <= '0;
            end
            if ((state_q == S_WAIT) && memRespValid && !wen_q) begin
                load_q <= ld_ext;
            end
        end
    end

    // reqReady is gated by rst_n so every output reads low while reset is held.
    assign reqReady    = rst_n && (state_q == S_IDLE);
    assign respValid   = (state_q == S_DONE);
    assign loadData    = load_q;
    assign accessErr   = err_q && (state_q == S_DONE);
    assign memReqValid = (state_q == S_REQ);
    assign memWen      = (state_q == S_REQ) && wen_q;
    assign memAddr     = (state_q == S_REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign memWdata    = (state_q == S_REQ) ? wdata_q : '0;
    assign memWmask    = (state_q == S_REQ) ? wmask_q : '0;

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid, reqReady;
    logic        readMemEnable, writeMemEnable;
    logic [2:0]  memOP;
    logic [31:0] addr, storeData;
    logic        respValid, respReady;
    logic [31:0] loadData;
    logic        accessErr;
    logic        memReqValid, memReqReady, memWen;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memWmask;
    logic        memRespValid;
    logic [31:0] memRdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady),
        .readMemEnable(readMemEnable), .writeMemEnable(writeMemEnable),
        .memOP(memOP), .addr(addr), .storeData(storeData),
        .respValid(respValid), .respReady(respReady),
        .loadData(loadData), .accessErr(accessErr),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memWen(memWen), .memAddr(memAddr), .memWdata(memWdata),
        .memWmask(memWmask), .memRespValid(memRespValid), .memRdata(memRdata)
    );

    // results of the most recent run_txn
    int          r_lat;
    bit          r_saw_mem, r_stable, r_idle_ok, r_timeout;
    logic [31:0] r_maddr, r_wdata, r_ldata;
    logic [3:0]  r_mask;
    logic        r_wen, r_err;

    // ---------------- reference model ----------------
    function automatic bit m_illegal(input bit rd, input bit wr, input int op, input longint a);
        int size;
        if (rd && wr) return 1'b1;
        if (!rd && !wr) return 1'b0;
        if (op == 3 || op >= 6) return 1'b1;
        if (wr && op >= 4) return 1'b1;
        size = 1 << (op % 4);
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] m_load(input int op, input longint a, input longint rdata);
        int nbytes;
        longint v, full;
        nbytes = 1 << (op % 4);
        if (nbytes == 4) return rdata[31:0];
        full = longint'(1) << (8 * nbytes);
        v = (rdata / (longint'(1) << (8 * (a % 4)))) % full;
        if (op < 4 && v >= full / 2) v = v - full + (longint'(1) << 32);
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_mask(input int op, input longint a);
        int nbytes;
        longint m;
        nbytes = 1 << (op % 4);
        if (nbytes == 4) return 4'hF;
        m = ((longint'(1) << nbytes) - 1) * (longint'(1) << (a % 4));
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input longint sd);
        longint v;
        case (op % 4)
            0:       v = (sd % 256) * 64'h01010101;
            1:       v = (sd % 65536) * 64'h00010001;
            default: v = sd;
        endcase
        return v[31:0];
    endfunction

    // ---------------- driver ----------------
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                           input int req_stall, input int mem_wait, input int resp_stall);
        int  cyc, req_cnt, wait_cnt, done_cnt;
        bit  pending, exit_next, got;
        r_lat = -1; r_saw_mem = 0; r_stable = 1; r_idle_ok = 0; r_timeout = 1;
        r_maddr = '0; r_wdata = '0; r_mask = '0; r_wen = 0; r_ldata = '0; r_err = 0;
        @(negedge clk);
        reqValid = 1; readMemEnable = rd; writeMemEnable = wr; memOP = op; addr = a; storeData = sd;
        @(negedge clk);
        reqValid = 0;
        readMemEnable = 1'($urandom); writeMemEnable = 1'($urandom);
        memOP = 3'($urandom); addr = $urandom; storeData = $urandom;
        cyc = 1; req_cnt = 0; wait_cnt = 0; done_cnt = 0;
        pending = 0; exit_next = 0; got = 0;
        for (int k = 0; k < 200; k++) begin
            if (exit_next) begin
                r_idle_ok = (reqReady === 1'b1) && (respValid === 1'b0);
                r_timeout = 0;
                break;
            end
            memReqReady = 0;
            if (pending) begin
                if (wait_cnt >= mem_wait) begin
                    memRespValid = 1; memRdata = rdata; pending = 0;
                end else begin
                    memRespValid = 0; memRdata = $urandom;
                end
                wait_cnt++;
            end else begin
                memRespValid = 1'($urandom_range(0, 1)); memRdata = $urandom;
            end
            if (memReqValid === 1'b1) begin
                if (!r_saw_mem) begin
                    r_maddr = memAddr; r_wdata = memWdata; r_mask = memWmask; r_wen = memWen;
                end else if (memAddr !== r_maddr || memWdata !== r_wdata ||
                             memWmask !== r_mask || memWen !== r_wen) begin
                    r_stable = 0;
                end
                r_saw_mem = 1;
                if (req_cnt >= req_stall) begin
                    memReqReady = 1; pending = 1; wait_cnt = 0;
                end
                req_cnt++;
            end
            if (respValid === 1'b1) begin
                if (!got) begin
                    got = 1; r_lat = cyc; r_ldata = loadData; r_err = accessErr;
                end else if (loadData !== r_ldata || accessErr !== r_err) begin
                    r_stable = 0;
                end
                if (done_cnt >= resp_stall) begin
                    respReady = 1; exit_next = 1;
                end else begin
                    respReady = 0;
                end
                done_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        memReqReady = 0; memRespValid = 0; respReady = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({respValid, loadData, accessErr, memReqValid, memWen, memAddr, memWdata, memWmask} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got resp=%b ld=%h err=%b mreq=%b wen=%b maddr=%h wd=%h wm=%h want all 0",
                     respValid, loadData, accessErr, memReqValid, memWen, memAddr, memWdata, memWmask);
        end
        rst_n = 1;
        @(negedge clk);
        total++;
        if (reqReady !== 1'b1) begin
            bad++; $display("FAIL reset_reqready: got %b want 1", reqReady);
        end
    endtask

    task automatic test_lb_sign;
        run_txn(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        total++;
        if (r_lat !== 3) begin bad++; $display("FAIL lb_latency: got %0d want 3", r_lat); end
        total++;
        if (r_maddr !== 32'h8000_0000 || r_mask !== 4'h0 || r_wen !== 1'b0) begin
            bad++; $display("FAIL lb_request: got addr=%h mask=%h wen=%b want 80000000 0 0", r_maddr, r_mask, r_wen);
        end
        total++;
        if (r_ldata !== 32'hFFFF_FF80 || r_err !== 1'b0) begin
            bad++; $display("FAIL lb_data: got %h err=%b want ffffff80 err=0", r_ldata, r_err);
        end
    endtask

    task automatic test_sh_upper;
        run_txn(0, 1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h1234_5678, 0, 0, 0);
        total++;
        if (r_wen !== 1'b1 || r_mask !== 4'b1100 || r_wdata !== 32'hBEEF_BEEF || r_maddr !== 32'h100) begin
            bad++;
            $display("FAIL sh_request: got wen=%b mask=%b wdata=%h addr=%h want 1 1100 beefbeef 00000100",
                     r_wen, r_mask, r_wdata, r_maddr);
        end
        total++;
        if (r_ldata !== 32'h0 || r_err !== 1'b0 || r_lat !== 3) begin
            bad++; $display("FAIL sh_resp: got ld=%h err=%b lat=%0d want 0 0 3", r_ldata, r_err, r_lat);
        end
    endtask

    task automatic test_misaligned;
        run_txn(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        total++;
        if (r_saw_mem !== 1'b0 || r_lat !== 1 || r_err !== 1'b1) begin
            bad++; $display("FAIL misaligned_lw: got mem=%b lat=%0d err=%b want 0 1 1", r_saw_mem, r_lat, r_err);
        end
    endtask

    task automatic test_backpressure;
        run_txn(1, 0, 3'b101, 32'h0000_0202, 32'h0, 32'hF00D_1234, 5, 0, 3);
        total++;
        if (r_stable !== 1'b1) begin bad++; $display("FAIL bp_stable: got %b want 1", r_stable); end
        total++;
        if (r_lat !== 8 || r_ldata !== 32'h0000_F00D) begin
            bad++; $display("FAIL bp_result: got lat=%0d ld=%h want 8 0000f00d", r_lat, r_ldata);
        end
        total++;
        if (r_idle_ok !== 1'b1 || r_timeout !== 1'b0) begin
            bad++; $display("FAIL bp_return_idle: got idle=%b timeout=%b want 1 0", r_idle_ok, r_timeout);
        end
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk);
        reqValid = 1; readMemEnable = 1; writeMemEnable = 0; memOP = 3'b010; addr = 32'h40;
        memReqReady = 1; memRespValid = 0;
        @(negedge clk);
        reqValid = 0;
        total++;
        if (memReqValid !== 1'b1) begin bad++; $display("FAIL rw_reach_req: got %b want 1", memReqValid); end
        @(negedge clk);
        memReqReady = 0;
        #1 rst_n = 0;
        #1;
        total++;
        if ({respValid, loadData, accessErr, memReqValid, memWen, memAddr, memWdata, memWmask} !== '0) begin
            bad++; $display("FAIL rw_async_reset: got resp=%b mreq=%b maddr=%h want 0 0 0", respValid, memReqValid, memAddr);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            memRespValid = 1; memRdata = $urandom;
            @(negedge clk);
            total++;
            if (respValid !== 1'b0 || memReqValid !== 1'b0 || reqReady !== 1'b1 || loadData !== 32'h0) begin
                bad++; $display("FAIL rw_ignore_resp: got resp=%b mreq=%b rdy=%b ld=%h want 0 0 1 0",
                                respValid, memReqValid, reqReady, loadData);
            end
        end
        memRespValid = 0;
        run_txn(1, 0, 3'b010, 32'h0000_0044, 32'h0, 32'hCAFE_0001, 0, 1, 0);
        total++;
        if (r_lat !== 4 || r_ldata !== 32'hCAFE_0001 || r_idle_ok !== 1'b1) begin
            bad++; $display("FAIL rw_next_req: got lat=%0d ld=%h idle=%b want 4 cafe0001 1", r_lat, r_ldata, r_idle_ok);
        end
    endtask

    task automatic test_noop;
        run_txn(0, 0, 3'b010, 32'h0000_1000, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 0);
        total++;
        if (r_lat !== 1 || r_saw_mem !== 1'b0 || r_ldata !== 32'h0 || r_err !== 1'b0) begin
            bad++; $display("FAIL noop: got lat=%0d mem=%b ld=%h err=%b want 1 0 0 0", r_lat, r_saw_mem, r_ldata, r_err);
        end
    endtask

    task automatic test_random;
        int          sel, op, rs, mw, ds, exp_lat;
        bit          rd, wr, ill, mem;
        logic [31:0] a, sd, rdata, exp_ld;
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            rd = (sel == 1) || (sel >= 2 && sel <= 5);
            wr = (sel == 1) || (sel >= 6);
            if (!rd && !wr) begin
                op = $urandom_range(0, 4);
                if (op == 3) op = 5;
            end else begin
                op = $urandom_range(0, 7);
            end
            a = $urandom; sd = $urandom; rdata = $urandom;
            rs = $urandom_range(0, 3); mw = $urandom_range(0, 3); ds = $urandom_range(0, 3);
            ill = m_illegal(rd, wr, op, longint'(a));
            mem = (rd || wr) && !ill;
            exp_lat = mem ? 3 + rs + mw : 1;
            exp_ld = (mem && rd) ? m_load(op, longint'(a), longint'(rdata)) : 32'h0;
            run_txn(rd, wr, 3'(op), a, sd, rdata, rs, mw, ds);
            total++;
            if (r_timeout !== 1'b0 || r_lat !== exp_lat) begin
                bad++; $display("FAIL rnd_latency[%0d]: got lat=%0d timeout=%b want %0d", n, r_lat, r_timeout, exp_lat);
            end
            total++;
            if (r_err !== ill || r_ldata !== exp_ld) begin
                bad++; $display("FAIL rnd_result[%0d]: got ld=%h err=%b want %h %b (rd=%b wr=%b op=%0d a=%h rdata=%h)",
                                n, r_ldata, r_err, exp_ld, ill, rd, wr, op, a, rdata);
            end
            total++;
            if (r_saw_mem !== mem || r_stable !== 1'b1 || r_idle_ok !== 1'b1) begin
                bad++; $display("FAIL rnd_handshake[%0d]: got mem=%b stable=%b idle=%b want %b 1 1",
                                n, r_saw_mem, r_stable, r_idle_ok, mem);
            end
            if (mem) begin
                total++;
                if (r_maddr !== {a[31:2], 2'b00} || r_wen !== wr ||
                    r_mask !== (wr ? m_mask(op, longint'(a)) : 4'h0) ||
                    (wr && r_wdata !== m_wdata(op, longint'(sd)))) begin
                    bad++; $display("FAIL rnd_memreq[%0d]: got addr=%h wen=%b mask=%h wd=%h (op=%0d a=%h sd=%h)",
                                    n, r_maddr, r_wen, r_mask, r_wdata, op, a, sd);
                end
            end
        end
    endtask

    initial begin
        rst_n = 0; reqValid = 0; readMemEnable = 0; writeMemEnable = 0; memOP = '0;
        addr = '0; storeData = '0; respReady = 0; memReqReady = 0; memRespValid = 0; memRdata = '0;
        test_reset();
        test_lb_sign();
        test_sh_upper();
        test_misaligned();
        test_backpressure();
        test_reset_in_wait();
        test_noop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

endmodule
